multicycle_control: RTL
=======================

# multicycle_control

Main control state machine for the multicycle 32-bit datapath. Sequences each instruction through fetch, decode, execute, memory and writeback steps and drives every datapath enable and mux select. It sits directly upstream of FullALU and supplies its `ALUOp`; the datapath routes `FuncCode` from the instruction register.

## Interface
- No parameters. State encodings and opcodes are fixed constants in the shared header.
- `Clk` input, 1 bit. Single clock; all state updates on the rising edge.
- `Reset` input, 1 bit. Synchronous, active-high.
- `Op` input, 6 bits. Opcode field `IR[31:26]`.
- `PCWrite`, `PCWriteCond` output, 1 bit each. PC write enables. The datapath ANDs `PCWriteCond` with ALU `Zero`.
- `IorD` output, 1 bit. Memory address select: 0 = PC, 1 = ALUOut register.
- `MemRead`, `MemWrite` output, 1 bit each. Memory strobes.
- `IRWrite` output, 1 bit. Instruction register load.
- `MemtoReg`, `RegDst`, `RegWrite` output, 1 bit each. Register file write controls.
- `ALUSrcA` output, 1 bit. 0 = PC, 1 = A register.
- `ALUSrcB` output, 2 bits. 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUOp` output, 2 bits. 00 = add, 01 = subtract, 10 = decode by FuncCode.
- `PCSource` output, 2 bits. 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `IllegalOp` output, 1 bit. Flags an unrecognised opcode.
- `State` output, 4 bits. Current state, for debug and verification.

## Operation
Moore machine: a 4-bit state register plus combinational output decode. `IllegalOp` is the only output that also depends on `Op`.

States, with their encoding, next state and non-zero outputs. Every output not listed is 0.
- `FETCH`=0 → `DECODE`. `MemRead`=1, `IorD`=0, `IRWrite`=1, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCWrite`=1, `PCSource`=00.
- `DECODE`=1. `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00. Next state by `Op`:
  - 100011 (lw) and 101011 (sw) → `MEMADDR`
  - 000000 (R-type) → `EXECUTE`
  - 000100 (beq) → `BRANCH`
  - 000010 (j) → `JUMP`
  - 001000 (addi) → `ADDIEXEC`
  - any other opcode → `FETCH`, with `IllegalOp`=1 for this cycle.
- `MEMADDR`=2 → `MEMREAD` for lw, `MEMWRITE` for sw. Selection uses `Op` sampled in this state. `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00.
- `MEMREAD`=3 → `MEMWB`. `MemRead`=1, `IorD`=1.
- `MEMWB`=4 → `FETCH`. `RegWrite`=1, `MemtoReg`=1, `RegDst`=0.
- `MEMWRITE`=5 → `FETCH`. `MemWrite`=1, `IorD`=1.
- `EXECUTE`=6 → `RWB`. `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10.
- `RWB`=7 → `FETCH`. `RegDst`=1, `RegWrite`=1, `MemtoReg`=0.
- `BRANCH`=8 → `FETCH`. `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01.
- `JUMP`=9 → `FETCH`. `PCWrite`=1, `PCSource`=10.
- `ADDIEXEC`=10 → `ADDIWB`. `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00.
- `ADDIWB`=11 → `FETCH`. `RegWrite`=1, `RegDst`=0, `MemtoReg`=0.
- Encodings 12–15 are unreachable. If entered, all outputs are 0 and next state is `FETCH`.

## Timing
- Reset: a rising edge with `Reset`=1 loads `FETCH`. This overrides any state, including reset mid-instruction. Outputs then show `FETCH` values. Before the first clock edge the state is undefined.
- Outputs change only after a rising edge, except `IllegalOp`, which follows `Op` combinationally while in `DECODE`.
- Cycles per instruction, counted from `FETCH`: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- `Op` must be stable from the edge ending `FETCH` through the last state of the instruction; the instruction register guarantees this.
- At most one of `MemRead` and `MemWrite` is asserted in any cycle.
- `RegWrite` is asserted for exactly one cycle per writeback instruction.

## Structure
- Shared header `multicycle_defs.vh` holds the state encoding localparams, the opcode constants and the `ALUOp` encodings. FullALU and the datapath use the same `ALUOp` constants.
- One sub-module: `opcode_decode`. Combinational; maps `Op` to a one-hot instruction class plus `IllegalOp`. The FSM uses it to select the next state out of `DECODE` and `MEMADDR`.

## Test plan
- `Reset`=1 for 2 cycles from mid-`MEMREAD` → `State`=0 on the next edge; `MemRead`=1, `IRWrite`=1, `PCWrite`=1, `ALUSrcB`=01.
- `Op`=100011 → `State` sequence 0,1,2,3,4,0. In state 4, `RegWrite`=1 and `MemtoReg`=1. `IorD`=1 in state 3 only.
- `Op`=000000 → sequence 0,1,6,7,0. `ALUOp`=10 in state 6. `RegDst`=1 and `RegWrite`=1 in state 7.
- `Op`=000100, then `Op`=000010 → sequences 0,1,8,0 and 0,1,9,0. State 8: `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01. State 9: `PCWrite`=1, `PCSource`=10.
- `Op`=101011, then `Op`=001000 → sequences 0,1,2,5,0 with `MemWrite`=1 in state 5, and 0,1,10,11,0 with `ALUSrcB`=10 in state 10.
- `Op`=111111 → `IllegalOp`=1 in state 1 only, then `State`=0. No `RegWrite` or `MemWrite` asserted at any point.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle control path: state encodings, opcodes,
// ALUOp codes and the per-state control word.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // Instruction class indices; CLASS_OPCODE[i] is the opcode of class i.
  localparam int CLS_N     = 6;
  localparam int CLS_LW    = 0;
  localparam int CLS_SW    = 1;
  localparam int CLS_RTYPE = 2;
  localparam int CLS_BEQ   = 3;
  localparam int CLS_J     = 4;
  localparam int CLS_ADDI  = 5;
  localparam logic [5:0] CLASS_OPCODE [CLS_N] =
    '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI};

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Moore output word for a state; unreachable encodings give all zeros.
  function automatic ctrl_t state_ctrl(input logic [3:0] s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALUOP_ADD;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADDR, S_ADDIEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNC;
      end
      S_RWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_opcode_decode.sv
// Combinational opcode classifier: one-hot instruction class plus an
// illegal flag when no class matches.
module opcode_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0]       op,
  output logic [CLS_N-1:0] cls,
  output logic             illegal
);

  for (genvar gi = 0; gi < CLS_N; gi++) begin : g_cls
    assign cls[gi] = (op == CLASS_OPCODE[gi]);
  end

  assign illegal = ~|cls;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath. Outputs are registered from the
// next state so they behave as a Moore decode of the current state.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  logic [3:0]       state_reg;
  logic [3:0]       state_next;
  ctrl_t            ctrl_reg;
  logic [CLS_N-1:0] cls;
  logic             op_illegal;

  opcode_decode u_decode (
    .op      (Op),
    .cls     (cls),
    .illegal (op_illegal)
  );

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        if (cls[CLS_LW] | cls[CLS_SW]) state_next = S_MEMADDR;
        else if (cls[CLS_RTYPE])       state_next = S_EXECUTE;
        else if (cls[CLS_BEQ])         state_next = S_BRANCH;
        else if (cls[CLS_J])           state_next = S_JUMP;
        else if (cls[CLS_ADDI])        state_next = S_ADDIEXEC;
        else                           state_next = S_FETCH;
      end
      S_MEMADDR:  state_next = cls[CLS_SW] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = S_MEMWB;
      S_EXECUTE:  state_next = S_RWB;
      S_ADDIEXEC: state_next = S_ADDIWB;
      default:    state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= S_FETCH;
      ctrl_reg  <= state_ctrl(S_FETCH);
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= state_ctrl(state_next);
    end
  end

  assign PCWrite     = ctrl_reg.pc_write;
  assign PCWriteCond = ctrl_reg.pc_write_cond;
  assign IorD        = ctrl_reg.iord;
  assign MemRead     = ctrl_reg.mem_read;
  assign MemWrite    = ctrl_reg.mem_write;
  assign IRWrite     = ctrl_reg.ir_write;
  assign MemtoReg    = ctrl_reg.mem_to_reg;
  assign RegDst      = ctrl_reg.reg_dst;
  assign RegWrite    = ctrl_reg.reg_write;
  assign ALUSrcA     = ctrl_reg.alu_src_a;
  assign ALUSrcB     = ctrl_reg.alu_src_b;
  assign ALUOp       = ctrl_reg.alu_op;
  assign PCSource    = ctrl_reg.pc_source;
  assign State       = state_reg;
  // Only output that looks at Op directly.
  assign IllegalOp   = (state_reg == S_DECODE) & op_illegal;

endmodule
